// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets inside the
// device slot, FSM state codes and CTRL/STATUS bit positions.
package int_ctrl_pkg;

  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_MODE = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SERV = 2'd2;

  localparam int CLAIM_BIT = 0;
  localparam int EOI_BIT   = 1;
  localparam int BUSY_BIT  = 31;
  localparam int STATE_LSB = 4;

endpackage

// File: rtl/int_ctrl_if.sv
// Bridge-side register bus of the interrupt controller slot.
interface int_ctrl_if;

  logic        we;
  logic [1:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, output addr, output wd, input rd);
  modport slave  (input we, input addr, input wd, output rd);

endinterface

// File: rtl/int_ctrl_prio_enc.sv
// Lowest-index-first priority encoder: bit 0 has the highest priority.
module int_prio_enc #(
  parameter int N_SRC = 6,
  parameter int ID_W  = 3
) (
  input  logic [N_SRC-1:0] req,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id    = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Programmable interrupt controller: per-source pending latch (edge or level),
// mask, fixed-priority winner selection and a claim/EOI service sequencer
// driving a one-hot registered hwint to the CPU.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int N_SRC = 6,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  int_ctrl_if.slave        bus,
  output logic [N_SRC-1:0] hwint
);

  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] irq_d;
  logic [1:0]       state;
  logic [ID_W-1:0]  cur_id;

  logic [N_SRC-1:0] eligible;
  logic [ID_W-1:0]  win_id;
  logic             win_vld;

  logic             wr_mask, wr_pend, wr_mode, wr_ctrl;
  logic             claim_act, eoi_act;
  logic [N_SRC-1:0] rise, clr, mode_sw, edge_nxt, pend_nxt;
  logic [1:0]       state_nxt;
  logic [ID_W-1:0]  id_nxt;
  logic [N_SRC-1:0] hwint_nxt;
  logic [31:0]      ctrl_rd;
  logic             unused_wd;

  assign eligible = pending & mask;

  int_prio_enc #(.N_SRC(N_SRC), .ID_W(ID_W)) u_enc (
    .req   (eligible),
    .id    (win_id),
    .valid (win_vld)
  );

  assign wr_mask = bus.we && (bus.addr == REG_MASK);
  assign wr_pend = bus.we && (bus.addr == REG_PEND);
  assign wr_mode = bus.we && (bus.addr == REG_MODE);
  assign wr_ctrl = bus.we && (bus.addr == REG_CTRL);

  // CLAIM only acts while a request is actually being presented; EOI only in service.
  assign claim_act = wr_ctrl && bus.wd[CLAIM_BIT] && (state == S_REQ) && win_vld;
  assign eoi_act   = wr_ctrl && bus.wd[EOI_BIT] && (state == S_SERV);

  assign unused_wd = ^bus.wd[31:N_SRC];

  // Pending update: edge bits latch rises (a rise beats any clear), level bits follow irq_in.
  always_comb begin
    rise     = irq_in & ~irq_d;
    clr      = (wr_pend ? bus.wd[N_SRC-1:0] : '0)
             | (claim_act ? (N_SRC'(1) << cur_id) : '0);
    mode_sw  = wr_mode ? (bus.wd[N_SRC-1:0] & ~mode) : '0;
    edge_nxt = (pending & ~clr) | rise;
    pend_nxt = ((mode & edge_nxt) | (~mode & irq_in)) & ~mode_sw;
  end

  // Service sequencer: IDLE -> REQ on any eligible source, REQ -> SERV on CLAIM, SERV -> IDLE on EOI.
  always_comb begin
    state_nxt = state;
    id_nxt    = cur_id;
    case (state)
      S_IDLE: begin
        if (win_vld) begin
          state_nxt = S_REQ;
          id_nxt    = win_id;
        end
      end
      S_REQ: begin
        if (!win_vld) begin
          state_nxt = S_IDLE;
        end else if (claim_act) begin
          state_nxt = S_SERV;
        end else begin
          id_nxt = win_id;
        end
      end
      S_SERV: begin
        if (eoi_act) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    hwint_nxt = (state_nxt == S_REQ) ? (N_SRC'(1) << id_nxt) : '0;
  end

  // Register state; everything clears asynchronously on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask    <= '0;
      pending <= '0;
      mode    <= '0;
      irq_d   <= '0;
      state   <= S_IDLE;
      cur_id  <= '0;
      hwint   <= '0;
    end else begin
      if (wr_mask) mask <= bus.wd[N_SRC-1:0];
      if (wr_mode) mode <= bus.wd[N_SRC-1:0];
      pending <= pend_nxt;
      irq_d   <= irq_in;
      state   <= state_nxt;
      cur_id  <= id_nxt;
      hwint   <= hwint_nxt;
    end
  end

  // Combinational register read-back for the addressed word.
  always_comb begin
    ctrl_rd                   = '0;
    ctrl_rd[BUSY_BIT]         = (state != S_IDLE);
    ctrl_rd[STATE_LSB +: 2]   = state;
    ctrl_rd[ID_W-1:0]         = cur_id;
    case (bus.addr)
      REG_MASK: bus.rd = 32'(mask);
      REG_PEND: bus.rd = 32'(pending);
      REG_MODE: bus.rd = 32'(mode);
      default:  bus.rd = ctrl_rd;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus a randomized run
// compared against a bit-level behavioural model of the controller.
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic [5:0] irq_in;
  logic [5:0] hwint;

  int_ctrl_if bus ();

  int_ctrl #(.N_SRC(6), .ID_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .irq_in (irq_in),
    .bus    (bus),
    .hwint  (hwint)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [5:0] m_mask, m_mode, m_pend, m_irqd, m_hw;
  int         m_state, m_id;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic void model_reset();
    m_mask = '0; m_mode = '0; m_pend = '0; m_irqd = '0; m_hw = '0;
    m_state = 0; m_id = 0;
  endfunction

  function automatic logic [31:0] model_rd(logic [1:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      2'd0: v[5:0] = m_mask;
      2'd1: v[5:0] = m_pend;
      2'd2: v[5:0] = m_mode;
      default: begin
        v[31]  = (m_state != 0);
        v[5:4] = m_state[1:0];
        v[2:0] = m_id[2:0];
      end
    endcase
    return v;
  endfunction

  // One clock edge of the controller, from the written rules.
  function automatic void model_edge(logic [5:0] irq, logic w, logic [1:0] a, logic [31:0] d);
    int         win;
    int         ns, nid;
    logic [5:0] np;
    bit         claim, eoi;
    win = -1;
    for (int i = 0; i < 6; i++)
      if (win < 0 && m_pend[i] && m_mask[i]) win = i;
    claim = w && a == 2'd3 && d[0] && m_state == 1 && win >= 0;
    eoi   = w && a == 2'd3 && d[1] && m_state == 2;
    for (int i = 0; i < 6; i++) begin
      if (m_mode[i]) begin
        np[i] = m_pend[i];
        if (w && a == 2'd1 && d[i]) np[i] = 1'b0;
        if (claim && i == m_id) np[i] = 1'b0;
        if (irq[i] && !m_irqd[i]) np[i] = 1'b1;
      end else begin
        np[i] = irq[i];
      end
      if (w && a == 2'd2 && d[i] && !m_mode[i]) np[i] = 1'b0;
    end
    ns  = m_state;
    nid = m_id;
    if (m_state == 0) begin
      if (win >= 0) begin ns = 1; nid = win; end
    end else if (m_state == 1) begin
      if (win < 0) ns = 0;
      else if (claim) ns = 2;
      else nid = win;
    end else if (m_state == 2) begin
      if (eoi) ns = 0;
    end else begin
      ns = 0;
    end
    m_hw = (ns == 1) ? 6'(1 << nid) : 6'h00;
    if (w && a == 2'd0) m_mask = d[5:0];
    if (w && a == 2'd2) m_mode = d[5:0];
    m_pend  = np;
    m_irqd  = irq;
    m_state = ns;
    m_id    = nid;
  endfunction

  // Apply one cycle of inputs (write is a single-cycle pulse) and advance the model.
  task automatic step(input logic [5:0] irq, input logic w, input logic [1:0] a, input logic [31:0] d);
    irq_in   = irq;
    bus.we   = w;
    bus.addr = a;
    bus.wd   = d;
    @(posedge clk);
    model_edge(irq, w, a, d);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a);
    bus.addr = a;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; irq_in = '0; bus.we = 1'b0; bus.addr = '0; bus.wd = '0;
    model_reset();
    #2;
    n_cmp++;
    if (hwint !== 6'h00) begin n_bad++; $display("FAIL reset_hwint: got %h want %h", hwint, 6'h00); end
    for (int a = 0; a < 4; a++) begin
      peek(2'(a));
      n_cmp++;
      if (bus.rd !== 32'h0) begin n_bad++; $display("FAIL reset_rd%0d: got %h want %h", a, bus.rd, 32'h0); end
    end
    @(posedge clk);
    #3 rst = 1'b1;
  endtask

  task automatic test_edge_basic();
    step(6'h00, 1'b1, REG_MODE, 32'h3F);
    step(6'h00, 1'b1, REG_MASK, 32'h01);
    step(6'h01, 1'b0, REG_MASK, 32'h0);
    peek(REG_PEND);
    n_cmp++;
    if (bus.rd !== 32'h1) begin n_bad++; $display("FAIL edge_pend: got %h want %h", bus.rd, 32'h1); end
    n_cmp++;
    if (hwint !== 6'h00) begin n_bad++; $display("FAIL edge_hwint_k: got %h want %h", hwint, 6'h00); end
    step(6'h00, 1'b0, REG_MASK, 32'h0);
    n_cmp++;
    if (hwint !== 6'h01) begin n_bad++; $display("FAIL edge_hwint_k1: got %h want %h", hwint, 6'h01); end
    step(6'h00, 1'b1, REG_CTRL, 32'h1);
    peek(REG_CTRL);
    n_cmp++;
    if (hwint !== 6'h00) begin n_bad++; $display("FAIL edge_claim_hwint: got %h want %h", hwint, 6'h00); end
    n_cmp++;
    if (bus.rd !== 32'h8000_0020) begin n_bad++; $display("FAIL edge_claim_status: got %h want %h", bus.rd, 32'h8000_0020); end
    step(6'h00, 1'b1, REG_CTRL, 32'h2);
    peek(REG_CTRL);
    n_cmp++;
    if (bus.rd !== 32'h0) begin n_bad++; $display("FAIL edge_eoi_status: got %h want %h", bus.rd, 32'h0); end
  endtask

  task automatic test_preempt();
    step(6'h00, 1'b1, REG_MASK, 32'h3F);
    step(6'h08, 1'b0, REG_MASK, 32'h0);
    step(6'h08, 1'b0, REG_MASK, 32'h0);
    n_cmp++;
    if (hwint !== 6'h08) begin n_bad++; $display("FAIL pre_hwint3: got %h want %h", hwint, 6'h08); end
    step(6'h0A, 1'b0, REG_MASK, 32'h0);
    step(6'h0A, 1'b0, REG_MASK, 32'h0);
    n_cmp++;
    if (hwint !== 6'h02) begin n_bad++; $display("FAIL pre_hwint1: got %h want %h", hwint, 6'h02); end
    step(6'h0A, 1'b1, REG_CTRL, 32'h1);
    peek(REG_CTRL);
    n_cmp++;
    if (bus.rd !== 32'h8000_0021) begin n_bad++; $display("FAIL pre_claim_status: got %h want %h", bus.rd, 32'h8000_0021); end
    peek(REG_PEND);
    n_cmp++;
    if (bus.rd !== 32'h08) begin n_bad++; $display("FAIL pre_claim_pend: got %h want %h", bus.rd, 32'h08); end
    step(6'h0A, 1'b1, REG_CTRL, 32'h2);
    step(6'h0A, 1'b0, REG_MASK, 32'h0);
    n_cmp++;
    if (hwint !== 6'h08) begin n_bad++; $display("FAIL pre_eoi_hwint: got %h want %h", hwint, 6'h08); end
    step(6'h0A, 1'b1, REG_CTRL, 32'h1);
    step(6'h00, 1'b1, REG_CTRL, 32'h2);
  endtask

  task automatic test_mask();
    step(6'h04, 1'b0, REG_MASK, 32'h0);
    step(6'h04, 1'b0, REG_MASK, 32'h0);
    n_cmp++;
    if (hwint !== 6'h04) begin n_bad++; $display("FAIL mask_hwint_on: got %h want %h", hwint, 6'h04); end
    step(6'h04, 1'b1, REG_MASK, 32'h0);
    step(6'h04, 1'b0, REG_MASK, 32'h0);
    peek(REG_CTRL);
    n_cmp++;
    if (hwint !== 6'h00) begin n_bad++; $display("FAIL mask_hwint_off: got %h want %h", hwint, 6'h00); end
    n_cmp++;
    if (bus.rd !== 32'h2) begin n_bad++; $display("FAIL mask_status_idle: got %h want %h", bus.rd, 32'h2); end
    step(6'h04, 1'b1, REG_MASK, 32'h04);
    step(6'h04, 1'b0, REG_MASK, 32'h0);
    n_cmp++;
    if (hwint !== 6'h04) begin n_bad++; $display("FAIL mask_hwint_again: got %h want %h", hwint, 6'h04); end
    step(6'h04, 1'b1, REG_PEND, 32'h04);
    step(6'h00, 1'b0, REG_MASK, 32'h0);
    n_cmp++;
    if (hwint !== 6'h00) begin n_bad++; $display("FAIL mask_w1c_idle: got %h want %h", hwint, 6'h00); end
    step(6'h00, 1'b1, REG_MASK, 32'h3F);
  endtask

  task automatic test_level();
    step(6'h00, 1'b1, REG_MODE, 32'h00);
    step(6'h10, 1'b0, REG_MASK, 32'h0);
    step(6'h10, 1'b0, REG_MASK, 32'h0);
    n_cmp++;
    if (hwint !== 6'h10) begin n_bad++; $display("FAIL lvl_hwint: got %h want %h", hwint, 6'h10); end
    step(6'h10, 1'b1, REG_CTRL, 32'h1);
    peek(REG_PEND);
    n_cmp++;
    if (bus.rd !== 32'h10) begin n_bad++; $display("FAIL lvl_claim_pend: got %h want %h", bus.rd, 32'h10); end
    step(6'h10, 1'b1, REG_CTRL, 32'h2);
    step(6'h10, 1'b0, REG_MASK, 32'h0);
    n_cmp++;
    if (hwint !== 6'h10) begin n_bad++; $display("FAIL lvl_repend: got %h want %h", hwint, 6'h10); end
    step(6'h00, 1'b0, REG_MASK, 32'h0);
    step(6'h00, 1'b0, REG_MASK, 32'h0);
    peek(REG_CTRL);
    n_cmp++;
    if (hwint !== 6'h00) begin n_bad++; $display("FAIL lvl_drop_hwint: got %h want %h", hwint, 6'h00); end
    n_cmp++;
    if (bus.rd[31] !== 1'b0) begin n_bad++; $display("FAIL lvl_drop_busy: got %b want %b", bus.rd[31], 1'b0); end
  endtask

  task automatic test_simul();
    step(6'h00, 1'b1, REG_MODE, 32'h3F);
    step(6'h01, 1'b0, REG_MASK, 32'h0);
    step(6'h01, 1'b0, REG_MASK, 32'h0);
    step(6'h00, 1'b0, REG_MASK, 32'h0);
    step(6'h01, 1'b1, REG_CTRL, 32'h1);
    peek(REG_CTRL);
    n_cmp++;
    if (bus.rd !== 32'h8000_0020) begin n_bad++; $display("FAIL sim_claim_status: got %h want %h", bus.rd, 32'h8000_0020); end
    peek(REG_PEND);
    n_cmp++;
    if (bus.rd !== 32'h01) begin n_bad++; $display("FAIL sim_claim_pend: got %h want %h", bus.rd, 32'h01); end
    step(6'h01, 1'b1, REG_CTRL, 32'h2);
    step(6'h01, 1'b0, REG_MASK, 32'h0);
    n_cmp++;
    if (hwint !== 6'h01) begin n_bad++; $display("FAIL sim_rereq: got %h want %h", hwint, 6'h01); end
    step(6'h00, 1'b0, REG_MASK, 32'h0);
    step(6'h01, 1'b1, REG_PEND, 32'h01);
    peek(REG_PEND);
    n_cmp++;
    if (bus.rd !== 32'h01) begin n_bad++; $display("FAIL sim_w1c_set: got %h want %h", bus.rd, 32'h01); end
    step(6'h01, 1'b1, REG_PEND, 32'h01);
    peek(REG_PEND);
    n_cmp++;
    if (bus.rd !== 32'h00) begin n_bad++; $display("FAIL sim_w1c_clr: got %h want %h", bus.rd, 32'h00); end
    step(6'h00, 1'b0, REG_MASK, 32'h0);
    n_cmp++;
    if (hwint !== 6'h00) begin n_bad++; $display("FAIL sim_idle: got %h want %h", hwint, 6'h00); end
  endtask

  task automatic test_async_reset();
    step(6'h04, 1'b0, REG_MASK, 32'h0);
    step(6'h04, 1'b0, REG_MASK, 32'h0);
    step(6'h04, 1'b1, REG_CTRL, 32'h1);
    step(6'h0C, 1'b0, REG_MASK, 32'h0);
    peek(REG_CTRL);
    n_cmp++;
    if (bus.rd !== 32'h8000_0022) begin n_bad++; $display("FAIL ar_serv_status: got %h want %h", bus.rd, 32'h8000_0022); end
    #1 rst = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (hwint !== 6'h00) begin n_bad++; $display("FAIL ar_hwint: got %h want %h", hwint, 6'h00); end
    peek(REG_PEND);
    n_cmp++;
    if (bus.rd !== 32'h0) begin n_bad++; $display("FAIL ar_pend: got %h want %h", bus.rd, 32'h0); end
    peek(REG_MASK);
    n_cmp++;
    if (bus.rd !== 32'h0) begin n_bad++; $display("FAIL ar_mask: got %h want %h", bus.rd, 32'h0); end
    peek(REG_CTRL);
    n_cmp++;
    if (bus.rd !== 32'h0) begin n_bad++; $display("FAIL ar_status: got %h want %h", bus.rd, 32'h0); end
    irq_in = '0;
    #1 rst = 1'b1;
  endtask

  task automatic test_random();
    logic [5:0]  irq_r;
    logic        w;
    logic [1:0]  a;
    logic [31:0] d;
    irq_r = '0;
    step(6'h00, 1'b1, REG_MASK, 32'h3F);
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 6; i++)
        if ($urandom_range(0, 3) == 0) irq_r[i] = ~irq_r[i];
      w = ($urandom_range(0, 9) < 3);
      a = 2'($urandom_range(0, 3));
      if (a == REG_CTRL) d = 32'($urandom_range(0, 3));
      else if (a == REG_PEND || a == REG_MASK) d = $urandom;
      else d = ($urandom_range(0, 3) == 0) ? $urandom : {26'd0, m_mode};
      irq_in = irq_r; bus.we = w; bus.addr = a; bus.wd = d;
      #1;
      n_cmp++;
      if (bus.rd !== model_rd(a)) begin
        n_bad++; $display("FAIL rnd_rd cyc%0d addr%0d: got %h want %h", c, a, bus.rd, model_rd(a));
      end
      @(posedge clk);
      model_edge(irq_r, w, a, d);
      #1;
      bus.we = 1'b0;
      n_cmp++;
      if (hwint !== m_hw) begin
        n_bad++; $display("FAIL rnd_hwint cyc%0d: got %h want %h", c, hwint, m_hw);
      end
      n_cmp++;
      if ($countones(hwint) > 1) begin
        n_bad++; $display("FAIL rnd_onehot cyc%0d: got %h want at most one bit", c, hwint);
      end
    end
  endtask

  initial begin
    test_reset();
    test_edge_basic();
    test_preempt();
    test_mask();
    test_level();
    test_simul();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Programmable interrupt controller between the microsystem's device IRQ lines (timer, I/O devices) and the CPU's hwint[5:0] input.
- Latches requests per source, applies mask and edge/level mode, and picks one winner by fixed priority.
- Sequences service with a claim/EOI handshake driven by CPU writes through the bridge.
- Presents one bridge-addressable device slot with four 32-bit registers.

Parameters:
N_SRC, 6, number of interrupt sources; equals the hwint width (range 1..8).
ID_W, 3, width of the source-id field; at least clog2(N_SRC).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset.
irq_in  input  N_SRC  raw device requests; bit 0 has the highest priority.
we  input  1  register write strobe from the bridge.
addr  input  2  word select within the slot (bridge address bits [3:2]).
wd  input  32  write data.
rd  output  32  combinational read data for addr.
hwint  output  N_SRC  one-hot registered interrupt request to the CPU.

Behaviour:
- Register map:
  - addr0 MASK: RW, bits[N_SRC-1:0]; 1 = enabled.
  - addr1 PENDING: read returns pending; write-1-to-clear, edge-mode bits only.
  - addr2 MODE: RW; 1 = edge, 0 = level.
  - addr3 CTRL/STATUS:
    - Write: wd[0] = CLAIM, wd[1] = EOI.
    - Read: [31] = busy (state != IDLE), [5:4] = state code, [ID_W-1:0] = cur_id. All other bits read 0.
- Reset (rst=0, asynchronous): mask, pending, mode, irq_d, cur_id, hwint = 0; state = IDLE. rd then reads all zeros.
- Edge mode:
  - irq_d holds the previous irq_in sample.
  - pending[i] sets on the clk edge where irq_in[i]=1 and irq_d[i]=0.
  - A clear (W1C or CLAIM) in the same cycle as a set loses: set wins.
- Level mode: pending[i] is the registered copy of irq_in[i] each cycle; W1C and CLAIM have no effect on it.
- eligible = pending & mask. The winner is the lowest-index eligible bit, taken from the priority encoder.
- FSM states: IDLE=0, REQ=1, SERV=2. Code 3 is unreachable and recovers to IDLE.
  - IDLE:
    - hwint = 0.
    - If eligible != 0: next state REQ, cur_id = winner.
  - REQ:
    - hwint = 1 << cur_id.
    - Each cycle cur_id is re-evaluated to the current winner, so a higher-priority arrival preempts before claim.
    - If eligible becomes 0 (masked, W1C, or level dropped): return to IDLE, hwint = 0.
    - CLAIM write: next state SERV, hwint = 0.
      - Clears pending[cur_id] if that source is edge mode.
      - Uses the cur_id held before the edge; a simultaneous new winner stays pending.
  - SERV:
    - hwint = 0. New requests only accumulate in pending; there is no nesting.
    - EOI write: next state IDLE. Any still-eligible source raises REQ one cycle later.
- Writes with no effect:
  - CLAIM outside REQ, and EOI outside SERV.
  - CLAIM and EOI both set in the same write: only the bit valid for the current state acts.
- Latency, edge mode: irq_in rises and is sampled at edge k → pending=1 after edge k → hwint asserted after edge k+1.
- Writes to MASK, MODE or PENDING take effect on the next clk edge. FSM decisions in that same cycle use the old values.
- Switching a bit from level to edge mode clears that pending bit.
- hwint is always 0 or one-hot.

Decomposition:
- Shared package int_ctrl_pkg holds:
  - register offsets REG_MASK=0, REG_PEND=1, REG_MODE=2, REG_CTRL=3;
  - state encoding S_IDLE/S_REQ/S_SERV;
  - CTRL bit positions CLAIM_BIT=0, EOI_BIT=1, BUSY_BIT=31.
- One sub-module, int_prio_enc: combinational lowest-index-first encoder over N_SRC bits. Outputs are the id and a valid flag.

Test Plan:
- Reset, edge: rst low then high; MODE=6'h3F, MASK=6'h01; pulse irq_in[0] → pending=1 after edge k, hwint=6'h01 after edge k+1. Then CLAIM → hwint=0, STATUS=32'h8000_0020. Then EOI → STATUS=0.
- Preemption: MASK=6'h3F, edge mode; raise irq_in[3], hwint=6'h08. Before claim, raise irq_in[1] → hwint=6'h02 next cycle. CLAIM → cur_id=1 in SERV, pending still 6'h08. EOI → hwint=6'h08.
- Masking: pending[2] set, hwint=6'h04; write MASK=0 → next cycle state IDLE, hwint=0. Write MASK=6'h04 → hwint=6'h04 again.
- Level re-pend: MODE=0, irq_in[4] held high; CLAIM then EOI → hwint=6'h10 again one cycle after EOI. Drop irq_in[4] during REQ → IDLE, hwint=0.
- Simultaneous events: CLAIM write on the same edge as a new rising edge on the claimed source → state SERV, pending bit stays 1. W1C plus set in the same cycle → bit 1.
- Async reset mid-SERV: assert rst between edges → hwint, pending, MASK and STATUS read 0 immediately, without a clk edge.
